// File: rtl/spi_master_arbiter.sv
// Two-requester SPI mode-0 master serialising 16-bit register frames.
// Define SPI_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module spi_master_arbiter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rnw0,
  input  logic       rnw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] rx_q, rx_d;
  logic        win_q, win_d;
  logic        rnw_q, rnw_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        gnt1;

`ifdef SPI_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign gnt1 = req1 & (~req0 | ptr_q);
`else
  assign gnt1 = req1 & ~req0;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    win_d    = win_q;
    rnw_d    = rnw_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SPI_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The done cycle is not a sample cycle: requesters drop req there.
        if ((req0 | req1) && !(done0_q | done1_q)) begin
          state_d = SHIFT;
          win_d   = gnt1;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          rx_d    = '0;
          if (gnt1) begin
            rnw_d = rnw1;
            sh_d  = {rnw1, addr1, rnw1 ? 8'h00 : wdata1};
          end else begin
            rnw_d = rnw0;
            sh_d  = {rnw0, addr0, rnw0 ? 8'h00 : wdata0};
          end
`ifdef SPI_ARB_RR_EN
          ptr_d = ~gnt1;
`endif
        end
      end
      SHIFT: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[14:0], spi_miso};
          end else if (bit_q == 5'd15) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + 5'd1;
            sh_d  = {sh_q[14:0], 1'b0};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_q == DivLast) begin
          state_d = IDLE;
          div_d   = '0;
          done0_d = ~win_q;
          done1_d = win_q;
          if (rnw_q && win_q) rdata1_d = rx_q[7:0];
          if (rnw_q && !win_q) rdata0_d = rx_q[7:0];
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      sh_q     <= '0;
      rx_q     <= '0;
      win_q    <= 1'b0;
      rnw_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef SPI_ARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      win_q    <= win_d;
      rnw_q    <= rnw_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SPI_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign spi_cs_n = (state_q == IDLE);
  assign spi_sclk = sclk_q;
  assign spi_mosi = (state_q != IDLE) & sh_q[15];
  assign busy     = (state_q != IDLE) | done0_q | done1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: CLK_DIV=4 and CLK_DIV=1 instances.
// A monitor captures MOSI/latency per frame and checks queued expectations.
module tb_spi_master_arbiter;

  typedef struct {
    int          d;
    bit          who;
    logic [15:0] frame;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0 [2];
  logic req1 [2];
  logic rnw0 [2];
  logic rnw1 [2];
  logic [6:0] addr0 [2];
  logic [6:0] addr1 [2];
  logic [7:0] wdata0 [2];
  logic [7:0] wdata1 [2];
  logic done0 [2];
  logic done1 [2];
  logic [7:0] rdata0 [2];
  logic [7:0] rdata1 [2];
  logic busy [2];
  logic cs_n [2];
  logic sclk [2];
  logic mosi [2];
  logic miso [2];

  exp_t sb [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit b2b = 1'b0;
  logic [15:0] resp [2];
  logic [15:0] tx [2];
  logic [15:0] cap [2];
  int rises [2];
  int fall_cyc [2];
  int last_done [2] = '{-1, -1};
  logic pcs [2] = '{1'b1, 1'b1};
  logic psclk [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso[0] = ~cs_n[0] & tx[0][15];
  assign miso[1] = ~cs_n[1] & tx[1][15];

  spi_master_arbiter #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .req1(req1[0]), .rnw0(rnw0[0]), .rnw1(rnw1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]),
    .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .done0(done0[0]), .done1(done1[0]),
    .rdata0(rdata0[0]), .rdata1(rdata1[0]), .busy(busy[0]),
    .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_master_arbiter #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .req1(req1[1]), .rnw0(rnw0[1]), .rnw1(rnw1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]),
    .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .done0(done0[1]), .done1(done1[1]),
    .rdata0(rdata0[1]), .rdata1(rdata1[1]), .busy(busy[1]),
    .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int d, bit who, logic [15:0] f,
                              logic [7:0] r0, logic [7:0] r1);
    exp_t e;
    e.d = d;
    e.who = who;
    e.frame = f;
    e.rd0 = r0;
    e.rd1 = r1;
    return e;
  endfunction

  task automatic mon_step(int d);
    exp_t e;
    int dv;
    dv = (d == 0) ? 4 : 1;
    if (pcs[d] && !cs_n[d]) begin
      if (d == 0 && b2b && last_done[d] >= 0)
        chk("frame_gap", 32'(cyc - last_done[d]), 32'd2);
      fall_cyc[d] = cyc;
      cap[d] = '0;
      rises[d] = 0;
      tx[d] = resp[d];
    end
    if (sclk[d] && !psclk[d]) begin
      cap[d] = {cap[d][14:0], mosi[d]};
      rises[d]++;
      tx[d] = {tx[d][14:0], 1'b0};
    end
    if (done0[d] || done1[d]) begin
      last_done[d] = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("dut_id", 32'(d), 32'(e.d));
        chk("winner", 32'(done1[d]), 32'(e.who));
        chk("both_done", 32'(done0[d] & done1[d]), 32'd0);
        chk("mosi_frame", 32'(cap[d]), 32'(e.frame));
        chk("sclk_rises", 32'(rises[d]), 32'd16);
        chk("done_latency", 32'(cyc - fall_cyc[d]), 32'(33 * dv));
        chk("rdata0", 32'(rdata0[d]), 32'(e.rd0));
        chk("rdata1", 32'(rdata1[d]), 32'(e.rd1));
      end
    end
    psclk[d] = sclk[d];
    pcs[d] = cs_n[d];
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic wait_done(int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(done0[d] || done1[d]) && t < 2000);
    chk("done_timeout", 32'(t < 2000), 32'd1);
  endtask

  task automatic wait_fall(int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (cs_n[d] && t < 100);
    chk("csn_timeout", 32'(t < 100), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; req1[i] = 0; rnw0[i] = 0; rnw1[i] = 0;
      addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
      resp[i] = '0; tx[i] = '0; cap[i] = '0;
      rises[i] = 0; fall_cyc[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done0", 32'(done0[0]), 32'd0);
    chk("rst_done1", 32'(done1[0]), 32'd0);
    chk("rst_rdata0", 32'(rdata0[0]), 32'd0);
    chk("rst_rdata1", 32'(rdata1[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_csn", 32'(cs_n[0]), 32'd1);
    chk("rst_sclk", 32'(sclk[0]), 32'd0);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write 0x12 <- 0x5A; MISO all ones must not touch rdata0
    rnw0[0] = 0; addr0[0] = 7'h12; wdata0[0] = 8'h5A; resp[0] = 16'hFFFF;
    sb.push_back(mk(0, 1'b0, 16'h125A, 8'h00, 8'h00));
    req0[0] = 1;
    wait_done(0);
    req0[0] = 0;
    chk("busy_in_done", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy[0]), 32'd0);
    chk("csn_after_done", 32'(cs_n[0]), 32'd1);
    repeat (3) @(negedge clk);

    // read 0x03 by requester 1; wdata1 must be ignored
    rnw1[0] = 1; addr1[0] = 7'h03; wdata1[0] = 8'hEE; resp[0] = 16'h12A5;
    sb.push_back(mk(0, 1'b1, 16'h8300, 8'h00, 8'hA5));
    req1[0] = 1;
    wait_done(0);
    req1[0] = 0;
    repeat (3) @(negedge clk);

    // contention: both requests held high
    rnw0[0] = 0; addr0[0] = 7'h21; wdata0[0] = 8'h11;
    rnw1[0] = 1; addr1[0] = 7'h44; resp[0] = 16'h003C;
`ifdef SPI_ARB_RR_EN
    sb.push_back(mk(0, 1'b0, 16'h2111, 8'h00, 8'hA5));
    sb.push_back(mk(0, 1'b1, 16'hC400, 8'h00, 8'h3C));
    sb.push_back(mk(0, 1'b0, 16'h2111, 8'h00, 8'h3C));
    sb.push_back(mk(0, 1'b1, 16'hC400, 8'h00, 8'h3C));
`else
    sb.push_back(mk(0, 1'b0, 16'h2111, 8'h00, 8'hA5));
    sb.push_back(mk(0, 1'b0, 16'h2111, 8'h00, 8'hA5));
    sb.push_back(mk(0, 1'b0, 16'h2111, 8'h00, 8'hA5));
    sb.push_back(mk(0, 1'b1, 16'hC400, 8'h00, 8'h3C));
`endif
    req0[0] = 1; req1[0] = 1;
    for (int i = 0; i < 4; i++) begin
      wait_done(0);
      if (i == 0) b2b = 1'b1;
`ifndef SPI_ARB_RR_EN
      if (i == 2) req0[0] = 0;
`endif
    end
    req0[0] = 0; req1[0] = 0; b2b = 1'b0;
    repeat (3) @(negedge clk);

    // reset at cycle 60 of a frame, req1 stays pending
    rnw1[0] = 1; addr1[0] = 7'h05; resp[0] = 16'h0077;
    req1[0] = 1;
    wait_fall(0);
    repeat (59) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_csn", 32'(cs_n[0]), 32'd1);
    chk("abort_sclk", 32'(sclk[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_mosi", 32'(mosi[0]), 32'd0);
    chk("abort_rdata1", 32'(rdata1[0]), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done1[0] | done0[0]), 32'd0);
    sb.push_back(mk(0, 1'b1, 16'h8500, 8'h00, 8'h77));
    rst_n = 1'b1;
    wait_done(0);
    req1[0] = 0;
    repeat (3) @(negedge clk);

    // CLK_DIV=1 read of 0x7F
    rnw0[1] = 1; addr0[1] = 7'h7F; resp[1] = 16'h00C3;
    sb.push_back(mk(1, 1'b0, 16'hFF00, 8'hC3, 8'h00));
    req0[1] = 1;
    wait_done(1);
    req0[1] = 0;
    repeat (5) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
